// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch.
//   stateT       : control FSM states (IDLE / RUN / PAUSE)
//   BCD_W        : width of one BCD digit
//   SEC_TENS_MAX : largest seconds-tens digit
//   DIGIT_MAX    : largest decimal digit
package stopwatch_pkg;

    localparam int unsigned BCD_W        = 4;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned DIGIT_MAX    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } stateT;

endpackage

// File: rtl/bcd_digit_counter.sv
// One wrapping BCD digit, 0..MAX.
//   inClock  in  : system clock
//   inResetN in  : asynchronous active-low reset
//   inc      in  : advance by one this cycle
//   clr      in  : force to zero (wins over inc)
//   digit    out : registered digit value
//   carry    out : combinational, high when inc wraps MAX -> 0
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = DIGIT_MAX
) (
    input  logic             inClock,
    input  logic             inResetN,
    input  logic             inc,
    input  logic             clr,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic atMax;

    assign atMax = (digit == BCD_W'(MAX));
    assign carry = inc & atMax;

    // Digit register; clear has priority so a same-cycle increment is dropped.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc) begin
            digit <= atMax ? '0 : digit + BCD_W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS stopwatch in the inClock domain, advanced by rising edges of the
// 1 Hz slowClock, which is sampled as data through a synchroniser.
// Optional lap freeze: define STOPWATCH_LAP_EN.
//   inClock   in  : 100 MHz system clock
//   inResetN  in  : asynchronous active-low reset
//   slowClock in  : 1 Hz square wave
//   startStop in  : pulse, start/pause toggle
//   clear     in  : pulse, zero count and stop
//   lap       in  : pulse, lap freeze toggle (only with STOPWATCH_LAP_EN)
//   secOnes/secTens/minOnes/minTens out : BCD digits
//   running   out : high while in RUN
//   rollover  out : one-cycle pulse on wrap to 00:00
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned MIN_TENS_MAX = 5
) (
    input  logic             inClock,
    input  logic             inResetN,
    input  logic             slowClock,
    input  logic             startStop,
    input  logic             clear,
    input  logic             lap,
    output logic [BCD_W-1:0] secOnes,
    output logic [BCD_W-1:0] secTens,
    output logic [BCD_W-1:0] minOnes,
    output logic [BCD_W-1:0] minTens,
    output logic             running,
    output logic             rollover
);

    logic [SYNC_STAGES-1:0] syncReg;
    logic                   syncPrev;
    logic                   tick;
    stateT                  state;
    stateT                  nextState;
    logic                   incSec;
    logic                   carrySecOnes;
    logic                   carrySecTens;
    logic                   carryMinOnes;
    logic                   wrap;
    logic [BCD_W-1:0]       liveSecOnes;
    logic [BCD_W-1:0]       liveSecTens;
    logic [BCD_W-1:0]       liveMinOnes;
    logic [BCD_W-1:0]       liveMinTens;

    // Synchroniser plus registered rising-edge detect on the last stage.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            syncReg  <= '0;
            syncPrev <= 1'b0;
            tick     <= 1'b0;
        end else begin
            syncReg[0] <= slowClock;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                syncReg[i] <= syncReg[i-1];
            end
            syncPrev <= syncReg[SYNC_STAGES-1];
            tick     <= syncReg[SYNC_STAGES-1] & ~syncPrev;
        end
    end

    // State register plus registered status outputs.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            state    <= IDLE;
            running  <= 1'b0;
            rollover <= 1'b0;
        end else begin
            state    <= nextState;
            running  <= (nextState == RUN);
            rollover <= wrap;
        end
    end

    // Next state; clear beats startStop beats tick, and ticks outside RUN are dropped.
    always_comb begin
        nextState = state;
        incSec    = 1'b0;
        if (clear) begin
            nextState = IDLE;
        end else if (startStop) begin
            case (state)
                IDLE:    nextState = RUN;
                RUN:     nextState = PAUSE;
                PAUSE:   nextState = RUN;
                default: nextState = IDLE;
            endcase
        end else if (tick && (state == RUN)) begin
            incSec = 1'b1;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) uSecOnes (
        .inClock(inClock), .inResetN(inResetN), .inc(incSec), .clr(clear),
        .digit(liveSecOnes), .carry(carrySecOnes)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) uSecTens (
        .inClock(inClock), .inResetN(inResetN), .inc(carrySecOnes), .clr(clear),
        .digit(liveSecTens), .carry(carrySecTens)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) uMinOnes (
        .inClock(inClock), .inResetN(inResetN), .inc(carrySecTens), .clr(clear),
        .digit(liveMinOnes), .carry(carryMinOnes)
    );

    // Carry out of the top digit is the wrap to 00:00.
    bcd_digit_counter #(.MAX(MIN_TENS_MAX)) uMinTens (
        .inClock(inClock), .inResetN(inResetN), .inc(carryMinOnes), .clr(clear),
        .digit(liveMinTens), .carry(wrap)
    );

`ifdef STOPWATCH_LAP_EN
    logic             frozen;
    logic [BCD_W-1:0] snapSecOnes;
    logic [BCD_W-1:0] snapSecTens;
    logic [BCD_W-1:0] snapMinOnes;
    logic [BCD_W-1:0] snapMinTens;

    // Lap freeze: snapshot taken on entry, live count keeps advancing underneath.
    always_ff @(posedge inClock or negedge inResetN) begin
        if (!inResetN) begin
            frozen      <= 1'b0;
            snapSecOnes <= '0;
            snapSecTens <= '0;
            snapMinOnes <= '0;
            snapMinTens <= '0;
        end else if (clear) begin
            frozen <= 1'b0;
        end else if (lap && (state != IDLE)) begin
            frozen <= ~frozen;
            if (!frozen) begin
                snapSecOnes <= liveSecOnes;
                snapSecTens <= liveSecTens;
                snapMinOnes <= liveMinOnes;
                snapMinTens <= liveMinTens;
            end
        end
    end

    assign secOnes = frozen ? snapSecOnes : liveSecOnes;
    assign secTens = frozen ? snapSecTens : liveSecTens;
    assign minOnes = frozen ? snapMinOnes : liveMinOnes;
    assign minTens = frozen ? snapMinTens : liveMinTens;
`else
    logic unusedLap;

    assign unusedLap = lap;
    assign secOnes   = liveSecOnes;
    assign secTens   = liveSecTens;
    assign minOnes   = liveMinOnes;
    assign minTens   = liveMinTens;
`endif

endmodule
